// File: rtl/dds_sweep_ctrl_if.sv
// dds_sweep_ctrl_if -- signal bundle between a sweep requester and the
// DDS sweep sequencer.
//   master : drives start/abort, sweep configuration and keep_on; observes
//            the DDS-facing outputs and sequencer status.
//   slave  : the sequencer side (dds_sweep_ctrl).
// Signals: start, abort, mode_cont, dir_down, keep_on, start_freq,
// stop_freq, step_freq, dwell_len (requester -> sequencer); dds_data,
// dds_we, dds_ce, busy, done, point_idx (sequencer -> DDS / requester).
interface dds_sweep_ctrl_if #(
    parameter int unsigned FW = 32,
    parameter int unsigned DW = 16,
    parameter int unsigned PW = 16
);
    logic          start;
    logic          abort;
    logic          mode_cont;
    logic          dir_down;
    logic          keep_on;
    logic [FW-1:0] start_freq;
    logic [FW-1:0] stop_freq;
    logic [FW-1:0] step_freq;
    logic [DW-1:0] dwell_len;
    logic [FW-1:0] dds_data;
    logic          dds_we;
    logic          dds_ce;
    logic          busy;
    logic          done;
    logic [PW-1:0] point_idx;

    modport master (
        output start, abort, mode_cont, dir_down, keep_on,
               start_freq, stop_freq, step_freq, dwell_len,
        input  dds_data, dds_we, dds_ce, busy, done, point_idx
    );

    modport slave (
        input  start, abort, mode_cont, dir_down, keep_on,
               start_freq, stop_freq, step_freq, dwell_len,
        output dds_data, dds_we, dds_ce, busy, done, point_idx
    );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl -- frequency-sweep sequencer feeding a DDS phase
// accumulator. On an accepted start it emits frequency words from
// start_freq towards stop_freq (clamped to stop_freq), one point every
// max(dwell_len,1) cycles, single pass or continuous, abortable anywhere.
// Ports:
//   clk     : rising-edge system clock
//   reset_n : asynchronous active-low reset
//   bus     : dds_sweep_ctrl_if.slave (configuration in; dds_data,
//             dds_we, dds_ce, busy, done, point_idx out -- all registered)
module dds_sweep_ctrl #(
    parameter int unsigned FW = 32,
    parameter int unsigned DW = 16,
    parameter int unsigned PW = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    dds_sweep_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {S_IDLE, S_EMIT, S_DWELL, S_DONE} state_e;

    state_e        state_q, state_d;
    logic [FW-1:0] data_q, data_d;       // current point, doubles as dds_data
    logic          last_q, last_d;       // current point is the last of the pass
    logic [DW-1:0] rem_q, rem_d;         // cycles left in the current point
    logic [PW-1:0] pidx_q, pidx_d;
    logic [FW-1:0] start_q, stop_q, step_q;
    logic [DW-1:0] dwell_q;
    logic          cont_q, down_q;
    logic          we_q, busy_q, done_q, ce_q;

    logic          accept;
    logic [FW:0]   sum_w, diff_w;
    logic          asc_last, desc_last, nxt_last;
    logic [FW-1:0] nxt;

    function automatic logic is_degen(input logic [FW-1:0] f0, input logic [FW-1:0] f1,
                                      input logic [FW-1:0] stp, input logic dn);
        return (stp == '0) || (f0 == f1) || (dn ? (f0 < f1) : (f0 > f1));
    endfunction

    function automatic logic [DW-1:0] dwell_m1(input logic [DW-1:0] d);
        return (d == '0) ? '0 : d - 1'b1;
    endfunction

    assign accept = (state_q == S_IDLE) && bus.start && !bus.abort;

    // Next point computed one bit wider so an ascending carry or a
    // descending underflow always clamps to stop instead of wrapping.
    always_comb begin
        sum_w     = {1'b0, data_q} + {1'b0, step_q};
        diff_w    = {1'b0, data_q} - {1'b0, stop_q};
        asc_last  = sum_w >= {1'b0, stop_q};
        desc_last = diff_w <= {1'b0, step_q};
        if (down_q) begin
            nxt_last = desc_last;
            nxt      = desc_last ? stop_q : (data_q - step_q);
        end else begin
            nxt_last = asc_last;
            nxt      = asc_last ? stop_q : sum_w[FW-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        last_d  = last_q;
        rem_d   = rem_q;
        pidx_d  = pidx_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_EMIT;
                    data_d  = bus.start_freq;
                    last_d  = is_degen(bus.start_freq, bus.stop_freq,
                                       bus.step_freq, bus.dir_down);
                    rem_d   = dwell_m1(bus.dwell_len);
                    pidx_d  = '0;
                end
            end
            S_EMIT, S_DWELL: begin
                if (rem_q != '0) begin
                    state_d = S_DWELL;
                    rem_d   = rem_q - 1'b1;
                end else if (!last_q) begin
                    state_d = S_EMIT;
                    data_d  = nxt;
                    last_d  = nxt_last;
                    rem_d   = dwell_m1(dwell_q);
                    pidx_d  = (pidx_q == '1) ? pidx_q : pidx_q + 1'b1;
                end else if (cont_q) begin
                    state_d = S_EMIT;
                    data_d  = start_q;
                    last_d  = is_degen(start_q, stop_q, step_q, down_q);
                    rem_d   = dwell_m1(dwell_q);
                    pidx_d  = '0;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Abort wins over every transition; dds_data keeps the last word.
        if (bus.abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            data_d  = data_q;
            pidx_d  = pidx_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            last_q  <= 1'b0;
            rem_q   <= '0;
            pidx_q  <= '0;
            start_q <= '0;
            stop_q  <= '0;
            step_q  <= '0;
            dwell_q <= '0;
            cont_q  <= 1'b0;
            down_q  <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ce_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            last_q  <= last_d;
            rem_q   <= rem_d;
            pidx_q  <= pidx_d;
            if (accept) begin
                start_q <= bus.start_freq;
                stop_q  <= bus.stop_freq;
                step_q  <= bus.step_freq;
                dwell_q <= bus.dwell_len;
                cont_q  <= bus.mode_cont;
                down_q  <= bus.dir_down;
            end
            // Status outputs follow the state being entered so they line
            // up with the registered state they describe.
            we_q   <= (state_d == S_EMIT);
            busy_q <= (state_d == S_EMIT) || (state_d == S_DWELL);
            done_q <= (state_d == S_DONE);
            ce_q   <= busy_q | bus.keep_on;
        end
    end

    assign bus.dds_data  = data_q;
    assign bus.dds_we    = we_q;
    assign bus.dds_ce    = ce_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.point_idx = pidx_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb_dds_sweep_ctrl -- directed plus randomized sweeps of dds_sweep_ctrl,
// compared cycle by cycle against a point-list reference model.
module tb_dds_sweep_ctrl;

    logic clk;
    logic reset_n;
    int   n_chk;
    int   n_err;

    dds_sweep_ctrl_if #(.FW(32), .DW(16), .PW(16)) bus ();

    dds_sweep_ctrl #(.FW(32), .DW(16), .PW(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: list of frequency words one pass visits.
    task automatic build_points(input longint unsigned s, input longint unsigned e,
                                input longint unsigned st, input logic dn,
                                output longint unsigned pts[$]);
        longint unsigned v;
        pts = {};
        if (st == 0 || s == e || (dn ? (s < e) : (s > e))) begin
            pts.push_back(s);
            return;
        end
        v = s;
        forever begin
            pts.push_back(v);
            if (v == e) break;
            if (dn) v = (v - e <= st) ? e : v - st;
            else    v = (v + st >= e) ? e : v + st;
        end
    endtask

    task automatic run_case(input logic [31:0] s, input logic [31:0] e,
                            input logic [31:0] st, input logic [15:0] dw,
                            input logic cont, input logic dn, input logic keep,
                            input int abort_at);
        longint unsigned pts[$];
        int unsigned     n, ef, total;
        int              post;
        logic            eb, ew, edn, prev_busy;
        logic [31:0]     ed, last_data;
        int unsigned     ei;

        build_points(longint'(s), longint'(e), longint'(st), dn, pts);
        n     = pts.size();
        ef    = (dw == 0) ? 1 : int'(dw);
        total = n * ef;

        @(negedge clk);
        bus.start_freq = s;  bus.stop_freq = e;  bus.step_freq = st;
        bus.dwell_len  = dw; bus.mode_cont = cont; bus.dir_down = dn;
        bus.keep_on    = keep;
        bus.start      = 1'b1;
        @(posedge clk);
        #1;
        bus.start      = 1'b0;
        // Captured configuration must ignore later changes.
        bus.start_freq = $urandom; bus.stop_freq = $urandom;
        bus.step_freq  = $urandom; bus.dwell_len = 16'($urandom);
        bus.mode_cont  = 1'($urandom); bus.dir_down = 1'($urandom);

        post      = 0;
        prev_busy = 1'b0;
        last_data = 32'(pts[0]);
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            ei = 0; edn = 1'b0;
            if (post > 0) begin
                ew = 1'b0; eb = 1'b0; ed = last_data;
            end else if (cont || k < int'(total)) begin
                ei = (int'(k) / ef) % n;
                ew = (k % ef) == 0;
                eb = 1'b1;
                ed = 32'(pts[ei]);
            end else if (k == int'(total)) begin
                ew = 1'b0; eb = 1'b0; edn = 1'b1; ed = 32'(pts[n-1]);
            end else begin
                ew = 1'b0; eb = 1'b0; ed = last_data;
            end
            chk("dds_we",   64'(bus.dds_we),   64'(ew));
            chk("dds_data", 64'(bus.dds_data), 64'(ed));
            chk("busy",     64'(bus.busy),     64'(eb));
            chk("done",     64'(bus.done),     64'(edn));
            chk("dds_ce",   64'(bus.dds_ce),   64'(prev_busy | keep));
            if (ew) chk("point_idx", 64'(bus.point_idx), 64'(ei));
            prev_busy = eb;
            last_data = ed;

            // A start while the sweep is running must be ignored.
            bus.start = (k == 0);
            if (post > 0) post++;
            if (k == abort_at && post == 0 && (cont || k <= int'(total))) begin
                bus.abort = 1'b1;
                post = 1;
            end else begin
                bus.abort = 1'b0;
            end
            if (post >= 3) break;
            if (!cont && post == 0 && k >= int'(total) + 1) break;
            if (k == 4999) chk("sweep_timeout", 64'(k), 64'(0));
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [31:0] rs, re, rst, span;
        logic [15:0] rdw;
        logic        rdn, rcont;
        int          rab;

        n_chk = 0;
        n_err = 0;
        bus.start = 0; bus.abort = 0; bus.mode_cont = 0; bus.dir_down = 0;
        bus.keep_on = 0; bus.start_freq = '0; bus.stop_freq = '0;
        bus.step_freq = '0; bus.dwell_len = '0;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_data", 64'(bus.dds_data),  64'(0));
        chk("rst_we",   64'(bus.dds_we),    64'(0));
        chk("rst_ce",   64'(bus.dds_ce),    64'(0));
        chk("rst_busy", 64'(bus.busy),      64'(0));
        chk("rst_done", 64'(bus.done),      64'(0));
        chk("rst_idx",  64'(bus.point_idx), 64'(0));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        run_case(32'd100, 32'd130, 32'd10, 16'd3, 1'b0, 1'b0, 1'b0, -1);
        run_case(32'd100, 32'd125, 32'd10, 16'd3, 1'b0, 1'b0, 1'b1, -1);
        run_case(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd2, 1'b0, 1'b0, 1'b0, -1);
        run_case(32'd50, 32'd20, 32'd15, 16'd0, 1'b0, 1'b1, 1'b1, -1);
        run_case(32'd100, 32'd300, 32'd0, 16'd2, 1'b0, 1'b0, 1'b0, -1);
        run_case(32'd200, 32'd100, 32'd10, 16'd1, 1'b0, 1'b0, 1'b0, -1);
        run_case(32'd100, 32'd130, 32'd10, 16'd3, 1'b1, 1'b0, 1'b0, 20);
        run_case(32'd100, 32'd130, 32'd10, 16'd3, 1'b0, 1'b0, 1'b0, 5);

        // Asynchronous reset in the middle of a sweep.
        @(negedge clk);
        bus.start_freq = 32'd1000; bus.stop_freq = 32'd2000; bus.step_freq = 32'd100;
        bus.dwell_len = 16'd2; bus.mode_cont = 1'b0; bus.dir_down = 1'b0;
        bus.keep_on = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_data", 64'(bus.dds_data),  64'(0));
        chk("mid_rst_we",   64'(bus.dds_we),    64'(0));
        chk("mid_rst_ce",   64'(bus.dds_ce),    64'(0));
        chk("mid_rst_busy", 64'(bus.busy),      64'(0));
        chk("mid_rst_done", 64'(bus.done),      64'(0));
        chk("mid_rst_idx",  64'(bus.point_idx), 64'(0));
        bus.keep_on = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        run_case(32'd500, 32'd530, 32'd7, 16'd2, 1'b0, 1'b0, 1'b0, -1);

        // start together with abort in IDLE must not launch a sweep.
        @(negedge clk);
        bus.start = 1'b1; bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("sa_busy", 64'(bus.busy),   64'(0));
            chk("sa_we",   64'(bus.dds_we), 64'(0));
            @(negedge clk);
        end

        for (int t = 0; t < 40; t++) begin
            rdn   = 1'($urandom);
            rcont = ($urandom % 4) == 0;
            rdw   = 16'($urandom_range(0, 4));
            span  = $urandom_range(0, 1500);
            rst   = ($urandom % 6 == 0) ? 32'd0 : $urandom_range(1, 300);
            rs    = ($urandom % 4 == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 1000) : $urandom;
            re    = rdn ? rs - span : rs + span;
            if (!rdn && ($urandom % 3 == 0)) re = 32'hFFFF_FFFF;
            if (rst != 0 && (rdn ? rs - re : re - rs) / rst > 30)
                rst = (rdn ? rs - re : re - rs) / 30 + 1;
            rab = rcont ? int'($urandom_range(0, 60))
                        : (($urandom % 3 == 0) ? int'($urandom_range(0, 30)) : -1);
            run_case(rs, re, rst, rdw, rcont, rdn, 1'($urandom), rab);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
Frequency-sweep sequencer sitting directly upstream of the DDS phase accumulator. It drives the DDS 32-bit frequency control word, its write strobe and its clock enable. On a start pulse it steps the frequency word from a programmed start value to a programmed stop value, up or down, by a fixed step, holding each point for a programmable dwell. It runs either one pass or continuously, and supports abort.

Parameters:
FW, 32, frequency control word width; matches the DDS frequency word input.
DW, 16, dwell counter width.
PW, 16, point index counter width.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
reset_n  in  1  asynchronous active-low reset.
start  in  1  single-cycle request; sampled only in IDLE.
abort  in  1  terminate the sweep; honoured in any state.
mode_cont  in  1  0 = single pass; 1 = continuous, restarting at start_freq.
dir_down  in  1  0 = ascending sweep; 1 = descending sweep.
keep_on  in  1  holds dds_ce high while idle.
start_freq  in  FW  first frequency word.
stop_freq  in  FW  last frequency word.
step_freq  in  FW  increment magnitude.
dwell_len  in  DW  cycles per point; 0 is treated as 1.
dds_data  out  FW  frequency word to the DDS.
dds_we  out  1  one-cycle write strobe to the DDS.
dds_ce  out  1  DDS clock enable.
busy  out  1  high while a sweep is active.
done  out  1  one-cycle pulse at the end of a single pass.
point_idx  out  PW  index of the current point in the current pass; saturates at all-ones.

Behaviour:
- Reset (reset_n=0): all state and all outputs are 0 immediately; the FSM enters IDLE.
- All outputs are registered.
- start_freq, stop_freq, step_freq, dwell_len, mode_cont and dir_down are captured on the accepted start. Later changes are ignored until the next start.
- FSM states are IDLE, EMIT, DWELL and DONE.
- IDLE:
  - start=1 and abort=0 → EMIT on the next edge.
  - abort has priority over start.
  - start while busy=1 is ignored.
- EMIT (1 cycle):
  - dds_we=1 and dds_data=current point.
  - point_idx = point number (first point = 0).
  - Next state is DWELL, or EMIT if the effective dwell is 1.
- Each point occupies exactly max(dwell_len,1) cycles, counted from its EMIT cycle. dds_we is high only in the first of those cycles.
- Start pulse accepted at edge T → first dds_we at cycle T+1.
- Next-point arithmetic uses FW+1 bits, so wrap-around is never a legal result:
  - Ascending: nxt = cur + step. If the carry is set or nxt >= stop, the next point is stop_freq and it is the last point.
  - Descending: if cur - stop <= step, the next point is stop_freq and it is the last point; otherwise nxt = cur - step.
- Degenerate cases produce exactly one point, start_freq, which is the last point:
  - step_freq = 0;
  - start_freq equals stop_freq;
  - start_freq already beyond stop_freq in the chosen direction.
- After the dwell of the last point:
  - Single pass (mode_cont=0): DONE for 1 cycle with done=1 and busy=0, then IDLE.
  - Continuous (mode_cont=1): the next EMIT reissues start_freq, point_idx restarts at 0, and there is no done pulse.
- abort in EMIT, DWELL or DONE:
  - IDLE on the next edge.
  - No further dds_we and no done pulse.
  - dds_data holds its last value.
- busy = 1 from the first EMIT through the last dwell cycle; 0 in DONE and IDLE.
- dds_ce = busy | keep_on, registered (one cycle behind busy/keep_on).
- dds_data holds the last emitted word while idle, so the DDS keeps running at the final frequency when keep_on=1.

Test Plan:
1. Basic ascending sweep: start=100, stop=130, step=10, dwell=3, single pass, start at T → dds_we at T+1, T+4, T+7, T+10 with data 100, 110, 120, 130 and point_idx 0..3; done=1 at T+13 only; busy low from T+13.
2. Clamp and overflow:
   - stop=125, otherwise as test 1 → data 100, 110, 120, 125.
   - start=0xFFFFFFF0, step=0x20, stop=0xFFFFFFFF → exactly two points, 0xFFFFFFF0 then 0xFFFFFFFF, with no wrapped word.
3. Descending sweep and dwell=0: dir_down=1, start=50, stop=20, step=15, dwell=0 → consecutive-cycle strobes with data 50, 35, 20; done 1 cycle after the last strobe.
4. Degenerate cases: step=0 → one point with data=start_freq, then done. Ascending with start=200, stop=100 → one point, 200.
5. Continuous mode and abort:
   - mode_cont=1 with the test 1 values → sequence 100, 110, 120, 130, 100, … every 3 cycles, point_idx wrapping to 0, no done.
   - abort during DWELL → no further dds_we, busy=0 on the next cycle, dds_data stays at the last word.
6. Reset, start and abort corner cases:
   - reset_n low mid-sweep → all outputs 0 asynchronously.
   - After release, start is accepted normally.
   - start and abort in the same IDLE cycle → stays IDLE.
   - start while busy → no effect on the sequence.
